// File: rtl/scr1_reset_seq_ctrl.sv
// Multi-channel reset sequencer: holds all pending channels low, then releases them in index order.
// Optional test bypass of the outputs is enabled with `define SCR1_RESET_SEQ_TEST_BYPASS_EN.
module scr1_reset_seq_ctrl #(
  parameter int CH_NUM        = 4,
  parameter int STAGES_AMOUNT = 2,
  parameter int HOLD_CYCLES   = 8,
  parameter int GAP_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] rst_req_in,
  input  logic              sw_rst_req,
`ifdef SCR1_RESET_SEQ_TEST_BYPASS_EN
  input  logic              test_mode,
  input  logic              test_rst_n,
`endif
  output logic [CH_NUM-1:0] rst_n_out,
  output logic [CH_NUM-1:0] rst_n_status,
  output logic              seq_busy,
  output logic              seq_done
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CH_NUM - 1);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_REL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [STAGES_AMOUNT-1:0][CH_NUM-1:0] r_sync;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [CH_NUM-1:0] r_out;
  logic [CH_NUM-1:0] r_status;
  logic              r_busy;
  logic              r_done;

  logic [CH_NUM-1:0] w_req;
  logic              w_any_req;
  logic [IDX_W-1:0]  w_r;
  logic [IDX_W-1:0]  w_s;
  logic [CH_NUM-1:0] w_keep;

  // Request synchroniser chain for the asynchronous per-channel requests
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {(STAGES_AMOUNT*CH_NUM){1'b0}};
    end else begin
      r_sync[0] <= rst_req_in;
      for (int k = 1; k < STAGES_AMOUNT; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Effective request vector, lowest requester and the restart index
  always_comb begin
    w_req    = r_sync[STAGES_AMOUNT-1];
    w_req[0] = w_req[0] | sw_rst_req;
    w_any_req = |w_req;
    w_r = {IDX_W{1'b0}};
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      w_r = w_req[i] ? IDX_W'(i) : w_r;
    end
    // An in-flight sequence may already be below the requester; restart from the lower point
    if ((r_state == ST_RUN) || (w_r < r_idx)) begin
      w_s = w_r;
    end else begin
      w_s = r_idx;
    end
    for (int j = 0; j < CH_NUM; j++) begin
      w_keep[j] = (j < int'(w_s));
    end
  end

  // Sequencer FSM: requests take priority over hold/gap counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_HOLD;
      r_cnt    <= {CNT_W{1'b0}};
      r_idx    <= {IDX_W{1'b0}};
      r_out    <= {CH_NUM{1'b0}};
      r_status <= {CH_NUM{1'b0}};
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (w_any_req) begin
      r_state  <= ST_HOLD;
      r_cnt    <= {CNT_W{1'b0}};
      r_idx    <= w_s;
      r_out    <= r_out & w_keep;
      r_status <= r_status & w_keep;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_status <= r_out;
      r_done   <= 1'b0;
      case (r_state)
        ST_HOLD: begin
          r_busy <= 1'b1;
          if (r_cnt == HOLD_LAST) begin
            r_state <= ST_REL;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_REL: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt        <= {CNT_W{1'b0}};
            r_out[r_idx] <= 1'b1;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= r_idx + IDX_W'(1);
              r_busy <= 1'b1;
            end
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_busy <= 1'b1;
          end
        end
        ST_RUN: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= ST_HOLD;
          r_cnt   <= {CNT_W{1'b0}};
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SCR1_RESET_SEQ_TEST_BYPASS_EN
  assign rst_n_out    = test_mode ? {CH_NUM{test_rst_n}} : r_out;
  assign rst_n_status = test_mode ? {CH_NUM{test_rst_n}} : r_status;
`else
  assign rst_n_out    = r_out;
  assign rst_n_status = r_status;
`endif
  assign seq_busy = r_busy;
  assign seq_done = r_done;

endmodule

// File: tb/tb_scr1_reset_seq_ctrl.sv
// Table-driven bench for scr1_reset_seq_ctrl at default parameters (CH_NUM=4, HOLD=8, GAP=4).
// Covers the SCR1_RESET_SEQ_TEST_BYPASS_EN ports when that macro is defined.
module tb_scr1_reset_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] rst_req_in;
  logic       sw_rst_req;
  logic [3:0] rst_n_out;
  logic [3:0] rst_n_status;
  logic       seq_busy;
  logic       seq_done;
`ifdef SCR1_RESET_SEQ_TEST_BYPASS_EN
  logic       test_mode;
  logic       test_rst_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit mono_en  = 1'b0;

  scr1_reset_seq_ctrl #(
    .CH_NUM(4), .STAGES_AMOUNT(2), .HOLD_CYCLES(8), .GAP_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rst_req_in  (rst_req_in),
    .sw_rst_req  (sw_rst_req),
`ifdef SCR1_RESET_SEQ_TEST_BYPASS_EN
    .test_mode   (test_mode),
    .test_rst_n  (test_rst_n),
`endif
    .rst_n_out   (rst_n_out),
    .rst_n_status(rst_n_status),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] req;
    logic       sw;
    logic [3:0] e_out;
    logic [3:0] e_st;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input int n, input logic [3:0] req, input logic sw, input logic [3:0] e_out,
                     input logic [3:0] e_st, input logic e_busy, input logic e_done);
    vec_t v;
    v.n = n; v.req = req; v.sw = sw; v.e_out = e_out; v.e_st = e_st;
    v.e_busy = e_busy; v.e_done = e_done;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_out, input logic [3:0] e_st,
                         input logic e_busy, input logic e_done);
    chk({tag, ".out"}, rst_n_out, e_out);
    chk({tag, ".status"}, rst_n_status, e_st);
    chk({tag, ".busy"}, {3'b000, seq_busy}, {3'b000, e_busy});
    chk({tag, ".done"}, {3'b000, seq_done}, {3'b000, e_done});
  endtask

  // Outputs must always form a contiguous run of released channels starting at channel 0
  always @(negedge clk) begin
    if (mono_en) begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (rst_n_out[i] && !rst_n_out[i-1]) begin
          n_fail++;
          $display("FAIL monotonic: rst_n_out=%b ch%0d high with ch%0d low", rst_n_out, i, i - 1);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    rst_req_in = 4'b0000;
    sw_rst_req = 1'b0;
`ifdef SCR1_RESET_SEQ_TEST_BYPASS_EN
    test_mode  = 1'b0;
    test_rst_n = 1'b0;
`endif
    tick(3);
    chk_all("reset", 4'b0000, 4'b0000, 1'b1, 1'b0);
    mono_en = 1'b1;
    rst_n = 1'b1;

    // Power-up sequence: channels at edges 12/16/20/24
    add(11, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    add(3,  4'b0000, 1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0011, 4'b0011, 1'b1, 1'b0);
    add(3,  4'b0000, 1'b0, 4'b0111, 4'b0011, 1'b1, 1'b0);
    add(4,  4'b0000, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add(1,  4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    // One-cycle request on ch2 from RUN
    add(1,  4'b0100, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0011, 4'b0011, 1'b1, 1'b0);
    add(11, 4'b0000, 1'b0, 4'b0011, 4'b0011, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0111, 4'b0011, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0);
    add(3,  4'b0000, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add(1,  4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    // Software request from RUN, then again while releasing ch1
    add(1,  4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(12, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(11, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    add(12, 4'b0000, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add(1,  4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    // ch1 request held for 30 cycles; timing restarts from synchronised deassertion
    add(30, 4'b0010, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    add(2,  4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    add(11, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0);
    add(8,  4'b0000, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add(1,  4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    // ch3 request lands on the final release edge: request wins, no done pulse
    add(1,  4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    add(21, 4'b0000, 1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0);
    add(1,  4'b1000, 1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0);
    add(11, 4'b0000, 1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0);
    add(1,  4'b0000, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b1);
    add(1,  4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);

    for (int v = 0; v < tbl.size(); v++) begin
      rst_req_in = tbl[v].req;
      sw_rst_req = tbl[v].sw;
      tick(tbl[v].n);
      chk_all($sformatf("vec%0d", v), tbl[v].e_out, tbl[v].e_st, tbl[v].e_busy, tbl[v].e_done);
    end
    rst_req_in = 4'b0000;
    sw_rst_req = 1'b0;

    // Synchronous reset asserted while ch1 is pending release
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(13);
    chk_all("midrel.pre", 4'b0001, 4'b0001, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick(1);
    chk_all("midrel.rst", 4'b0000, 4'b0000, 1'b1, 1'b0);
`ifdef SCR1_RESET_SEQ_TEST_BYPASS_EN
    test_mode  = 1'b1;
    test_rst_n = 1'b1;
    #1;
    chk("bypass.out1", rst_n_out, 4'b1111);
    chk("bypass.st1", rst_n_status, 4'b1111);
    test_rst_n = 1'b0;
    #1;
    chk("bypass.out0", rst_n_out, 4'b0000);
    test_mode = 1'b0;
    #1;
    chk("bypass.off", rst_n_out, 4'b0000);
`endif
    rst_n = 1'b1;
    tick(11);
    chk_all("midrel.e11", 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick(1);
    chk_all("midrel.e12", 4'b0001, 4'b0000, 1'b1, 1'b0);
`ifdef SCR1_RESET_SEQ_TEST_BYPASS_EN
    test_mode  = 1'b1;
    test_rst_n = 1'b0;
    tick(1);
    chk("bypass.mask", rst_n_out, 4'b0000);
    test_mode = 1'b0;
    #1;
    chk("bypass.restore", rst_n_out, 4'b0001);
    tick(11);
`else
    tick(12);
`endif
    chk_all("midrel.e24", 4'b1111, 4'b0111, 1'b0, 1'b1);
    tick(1);
    chk_all("midrel.e25", 4'b1111, 4'b1111, 1'b0, 1'b0);

    mono_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
